// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared timing constants, glyph geometry and colour type for the text renderer
package vga_text_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    localparam int COLS     = 80;
    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 16;
    localparam int PIPE_LAT = 5;

    typedef logic [11:0] rgb444_t;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First cell of a text row: row * 80 as (row << 6) + (row << 4).
    function automatic logic [11:0] row_base(input logic [5:0] row);
        return {row, 6'b0} + {2'b0, row, 4'b0};
    endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel/line counters with active-area and sync decode
module vga_sync_gen
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       hs_n,
    output logic       vs_n,
    output logic       first_px
);

    localparam logic [9:0] H_LAST   = 10'(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [9:0] V_LAST   = 10'(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        active   = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
        hs_n     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_n     = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        first_px = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

endmodule

// File: rtl/vga_text_render.sv
// rtl/vga_text_render.sv - 80-column text-mode VGA scan-out with text buffer and font ROM pipeline
module vga_text_render
    import vga_text_pkg::*;
#(
    parameter int      addr_width = 31,
    parameter int      H_ACTIVE   = DEF_H_ACTIVE,
    parameter int      H_FP       = DEF_H_FP,
    parameter int      H_SYNC     = DEF_H_SYNC,
    parameter int      H_BP       = DEF_H_BP,
    parameter int      V_ACTIVE   = DEF_V_ACTIVE,
    parameter int      V_FP       = DEF_V_FP,
    parameter int      V_SYNC     = DEF_V_SYNC,
    parameter int      V_BP       = DEF_V_BP,
    parameter rgb444_t FG_COLOR   = 12'hFFF,
    parameter rgb444_t BG_COLOR   = 12'h000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    output logic [addr_width-1:0] addr_read,
    input  logic [7:0]            char_read,
    output logic [11:0]           font_addr,
    input  logic [7:0]            font_data,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start
);

    localparam int D     = PIPE_LAT - 1;
    localparam int HX_W  = $clog2(GLYPH_W);
    localparam int ROW_W = $clog2(GLYPH_H);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       active;
    logic       hs_n;
    logic       vs_n;
    logic       first_px;

    vga_sync_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .active   (active),
        .hs_n     (hs_n),
        .vs_n     (vs_n),
        .first_px (first_px)
    );

    logic [11:0]                 cell_addr;
    logic [11:0]                 cell_q;
    logic [D-1:0]                act_d;
    logic [D-1:0]                hs_d;
    logic [D-1:0]                vs_d;
    logic [D-1:0]                first_d;
    logic [D-1:0][HX_W-1:0]      hx_d;
    logic [1:0][ROW_W-1:0]       row_d;
    rgb444_t                     rgb_q;
    logic                        first_q;

    always_comb begin
        cell_addr = '0;
        if (active) begin
            cell_addr = row_base(v_cnt[9:ROW_W]) + {5'b0, h_cnt[9:HX_W]};
        end
    end

    // Stage taps: cell_q is t+1, font_addr t+3, outputs t+5; the D-deep side
    // delays feed the output register so syncs and pixels leave together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_q    <= '0;
            font_addr <= '0;
            row_d     <= '0;
            act_d     <= '0;
            hx_d      <= '0;
            first_d   <= '0;
            // Sync taps reset to the inactive level so no stray pulse drains out after release.
            hs_d      <= '1;
            vs_d      <= '1;
            rgb_q     <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            first_q   <= 1'b0;
        end else if (pix_en) begin
            cell_q    <= cell_addr;
            row_d     <= {row_d[0], v_cnt[ROW_W-1:0]};
            font_addr <= {char_read, row_d[1]};
            act_d     <= {act_d[D-2:0], active};
            hx_d      <= {hx_d[D-2:0], h_cnt[HX_W-1:0]};
            first_d   <= {first_d[D-2:0], first_px};
            hs_d      <= {hs_d[D-2:0], hs_n};
            vs_d      <= {vs_d[D-2:0], vs_n};
            if (act_d[D-1]) begin
                rgb_q <= font_data[3'(GLYPH_W - 1) - hx_d[D-1]] ? FG_COLOR : BG_COLOR;
            end else begin
                rgb_q <= '0;
            end
            hsync     <= hs_d[D-1];
            vsync     <= vs_d[D-1];
            first_q   <= first_d[D-1];
        end
    end

    assign addr_read   = {{(addr_width - 12){1'b0}}, cell_q};
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    // first_q holds across disabled clocks; the enable gate trims it to one clk.
    assign frame_start = first_q & pix_en;

endmodule

// File: tb/tb_vga_text_render.sv
// tb/tb_vga_text_render.sv - directed self-checking bench for vga_text_render
module tb_vga_text_render;

    localparam int VA    = 32;
    localparam int VF    = 4;
    localparam int VS    = 2;
    localparam int VB    = 3;
    localparam int VT    = VA + VF + VS + VB;
    localparam int HT    = 800;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b1;
    logic [30:0] addr_read;
    logic [7:0]  char_read = 8'h00;
    logic [11:0] font_addr;
    logic [7:0]  font_data = 8'h00;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, frame_start;

    int n = 0;
    int pass_cnt = 0;
    int total = 0;
    int fs_count = 0;
    int hs_low = 0;

    vga_text_render #(
        .addr_width (31),
        .V_ACTIVE   (VA),
        .V_FP       (VF),
        .V_SYNC     (VS),
        .V_BP       (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .addr_read   (addr_read),
        .char_read   (char_read),
        .font_addr   (font_addr),
        .font_data   (font_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] text_at(input logic [30:0] a);
        if (a == 31'd0)  return 8'h41;
        if (a == 31'd81) return 8'h42;
        return 8'h00;
    endfunction

    function automatic logic [7:0] font_at(input logic [11:0] a);
        if (a == 12'h413)      return 8'h80;
        if (a[11:4] == 8'h41)  return 8'hFF;
        if (a[11:4] == 8'h42)  return 8'h3C;
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        char_read <= text_at(addr_read);
        font_data <= font_at(font_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        pix_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n++;
        fs_count += int'(frame_start);
        if (n <= HT && hsync === 1'b0) hs_low++;
    endtask

    task automatic slow_tick();
        pix_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pix_en = 1'b0;
        repeat (3) @(negedge clk);
        n++;
    endtask

    task automatic adv_to(input int target);
        while (n < target) tick();
    endtask

    function automatic logic [11:0] rgb();
        return {vga_r, vga_g, vga_b};
    endfunction

    initial begin
        rst = 1'b1;
        pix_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_hsync", 32'(hsync), 32'd1);
        chk("reset_vsync", 32'(vsync), 32'd1);
        chk("reset_rgb", 32'(rgb()), 32'h000);
        chk("reset_addr", 32'(addr_read), 32'd0);
        chk("reset_font_addr", 32'(font_addr), 32'd0);
        chk("reset_frame_start", 32'(frame_start), 32'd0);

        rst = 1'b0;
        n = 0;
        fs_count = 0;
        hs_low = 0;

        adv_to(1);
        chk("addr_0_0", 32'(addr_read), 32'd0);
        adv_to(4);
        chk("rgb_before_latency", 32'(rgb()), 32'h000);
        chk("frame_start_early", 32'(frame_start), 32'd0);
        adv_to(5);
        chk("rgb_first_pixel", 32'(rgb()), 32'hFFF);
        chk("frame_start_first", 32'(frame_start), 32'd1);
        adv_to(6);
        chk("frame_start_one_cycle", 32'(frame_start), 32'd0);

        adv_to(660);
        chk("hsync_high_655", 32'(hsync), 32'd1);
        adv_to(661);
        chk("hsync_low_656", 32'(hsync), 32'd0);
        adv_to(756);
        chk("hsync_low_751", 32'(hsync), 32'd0);
        adv_to(757);
        chk("hsync_high_752", 32'(hsync), 32'd1);
        adv_to(HT);
        chk("hsync_low_width", 32'(hs_low), 32'd96);
        adv_to(HT + 660);
        chk("hsync_line1_high", 32'(hsync), 32'd1);
        adv_to(HT + 661);
        chk("hsync_line1_low", 32'(hsync), 32'd0);

        adv_to(3 * HT + 3);
        chk("font_addr_0x413", 32'(font_addr), 32'h413);
        adv_to(3 * HT + 4);
        chk("rgb_blank_799_2", 32'(rgb()), 32'h000);
        for (int i = 0; i < 8; i++) begin
            adv_to(3 * HT + 5 + i);
            chk($sformatf("glyph_v3_h%0d", i), 32'(rgb()), (i == 0) ? 32'hFFF : 32'h000);
        end
        adv_to(3 * HT + 13);
        chk("glyph_cell1_empty", 32'(rgb()), 32'h000);

        adv_to(16 * HT + 9);
        chk("addr_8_16", 32'(addr_read), 32'd81);
        adv_to(16 * HT + 13);
        chk("rgb_8_16", 32'(rgb()), 32'h000);
        adv_to(16 * HT + 15);
        chk("rgb_10_16", 32'(rgb()), 32'hFFF);
        adv_to(16 * HT + 640);
        chk("addr_639_16", 32'(addr_read), 32'd159);
        adv_to(16 * HT + 641);
        chk("addr_640_16", 32'(addr_read), 32'd0);
        adv_to(16 * HT + 645);
        chk("rgb_blank_640_16", 32'(rgb()), 32'h000);

        adv_to(31 * HT + 640);
        chk("addr_639_last_line", 32'(addr_read), 32'd159);
        adv_to(32 * HT + 1);
        chk("addr_0_first_blank_line", 32'(addr_read), 32'd0);
        adv_to(32 * HT + 5);
        chk("rgb_blank_line", 32'(rgb()), 32'h000);

        adv_to((VA + VF) * HT + 4);
        chk("vsync_high_before", 32'(vsync), 32'd1);
        adv_to((VA + VF) * HT + 5);
        chk("vsync_low_start", 32'(vsync), 32'd0);
        adv_to((VA + VF + VS) * HT + 4);
        chk("vsync_low_end", 32'(vsync), 32'd0);
        adv_to((VA + VF + VS) * HT + 5);
        chk("vsync_high_after", 32'(vsync), 32'd1);

        adv_to(FRAME + 1);
        chk("addr_wrap", 32'(addr_read), 32'd0);
        adv_to(FRAME + 5);
        chk("frame_start_wrap", 32'(frame_start), 32'd1);
        chk("frame_start_count", 32'(fs_count), 32'd2);
        chk("rgb_wrap_first_pixel", 32'(rgb()), 32'hFFF);

        adv_to(FRAME + 3 * HT);
        while (n < FRAME + 3 * HT + 13) begin
            slow_tick();
            if (n == FRAME + 3 * HT + 3)
                chk("slow_font_addr", 32'(font_addr), 32'h413);
            if (n >= FRAME + 3 * HT + 5)
                chk($sformatf("slow_glyph_h%0d", n - (FRAME + 3 * HT + 5)), 32'(rgb()),
                    (n == FRAME + 3 * HT + 5) ? 32'hFFF : 32'h000);
            if (n == FRAME + 3 * HT + 5) begin
                repeat (10) @(negedge clk);
                chk("hold_rgb", 32'(rgb()), 32'hFFF);
                chk("hold_font_addr", 32'(font_addr), 32'h413);
                chk("hold_hsync", 32'(hsync), 32'd1);
                chk("hold_frame_start", 32'(frame_start), 32'd0);
            end
        end

        adv_to(FRAME + 20 * HT + 700);
        chk("pre_reset_hsync", 32'(hsync), 32'd0);
        chk("pre_reset_font_addr", 32'(font_addr), 32'h414);
        rst = 1'b1;
        #1;
        chk("midreset_hsync", 32'(hsync), 32'd1);
        chk("midreset_vsync", 32'(vsync), 32'd1);
        chk("midreset_rgb", 32'(rgb()), 32'h000);
        chk("midreset_font_addr", 32'(font_addr), 32'd0);
        chk("midreset_addr", 32'(addr_read), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        hs_low = 0;
        adv_to(5);
        chk("post_reset_rgb", 32'(rgb()), 32'hFFF);
        chk("post_reset_frame_start", 32'(frame_start), 32'd1);
        adv_to(660);
        chk("post_reset_hsync_high", 32'(hsync), 32'd1);
        adv_to(661);
        chk("post_reset_hsync_low", 32'(hsync), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
